// File: rtl/sequence_checker_if.sv
// Bundles the round control, memory read port, buttons and LEDs of the sequence checker.
// The slave modport is the checker side; master is the game FSM / memory / pin side.
interface sequence_checker_if #(
  parameter int MAX_LEN = 8,
  parameter int CODE_W  = 2
);
  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic              start;
  logic [LEN_W-1:0]  round_len;
  logic [3:0]        btn;
  logic              rd_en;
  logic [PTR_W-1:0]  rd_addr;
  logic [CODE_W-1:0] rd_data;
  logic              busy;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [PTR_W-1:0]  press_idx;
  logic [3:0]        echo_led;

  modport slave (
    input  start, round_len, btn, rd_data,
    output rd_en, rd_addr, busy, pass, fail, timeout, press_idx, echo_led
  );

  modport master (
    output start, round_len, btn, rd_data,
    input  rd_en, rd_addr, busy, pass, fail, timeout, press_idx, echo_led
  );
endinterface

// File: rtl/sequence_checker.sv
// Simon player-side checker: conditions buttons, fetches expected codes and judges each press.
// Define SEQ_CHECK_TIMEOUT_EN to enable the per-press timeout (TIMEOUT_CYC cycles).
//
//   state       | meaning
//   ST_IDLE     | waiting for start; latches round length
//   ST_FETCH    | rd_en pulse for the current press index
//   ST_WAIT_RD  | capture expected code from memory, arm timeout
//   ST_PRESS    | wait for a debounced press edge and judge it
//   ST_RELEASE  | wait for all buttons released, then advance or pass
//   ST_PASS     | one-cycle pass pulse
//   ST_FAIL     | one-cycle fail pulse (timeout qualifies it)
module sequence_checker #(
  parameter int MAX_LEN      = 8,
  parameter int CODE_W       = 2,
  parameter int DEBOUNCE_CYC = 4
`ifdef SEQ_CHECK_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 200
`endif
) (
  input logic              clk,
  input logic              rst_n,
  sequence_checker_if.slave bus
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_PRESS,
    ST_RELEASE,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t state, state_nxt;

  logic [3:0]             sync_a, sync_b;
  logic [3:0]             db, db_prev;
  logic [3:0][DB_W-1:0]   db_cnt;
  logic [3:0]             press_edge;

  logic [LEN_W-1:0]  len_q;
  logic [PTR_W-1:0]  idx;
  logic [CODE_W-1:0] exp_q;
  logic [3:0]        exp_hot;
  logic              idx_last;

  logic len_ld, idx_clr, idx_inc, exp_ld;

  // Two-flop synchroniser, then a per-bit stability counter that only lets the
  // debounced level follow after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      db      <= '0;
      db_prev <= '0;
      db_cnt  <= '0;
    end else begin
      sync_a  <= bus.btn;
      sync_b  <= sync_a;
      db_prev <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db[i]     <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_edge = db & ~db_prev;
  assign exp_hot    = 4'b0001 << exp_q;
  assign idx_last   = (LEN_W'(idx) == (len_q - LEN_W'(1)));

`ifdef SEQ_CHECK_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMR_W-1:0] tmr;
  logic             to_hit;
  logic             to_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_ld    = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    exp_ld    = 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          len_ld  = 1'b1;
          idx_clr = 1'b1;
          if ((bus.round_len == '0) || (bus.round_len > LEN_W'(MAX_LEN))) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: begin
        exp_ld    = 1'b1;
        state_nxt = ST_PRESS;
      end
      ST_PRESS: begin
        // A single correct button makes db exactly one-hot of the expected code;
        // anything else (wrong code or several buttons) is a miss.
        if (press_edge != '0) begin
          state_nxt = (db == exp_hot) ? ST_RELEASE : ST_FAIL;
        end
`ifdef SEQ_CHECK_TIMEOUT_EN
        else if (tmr == '0) begin
          to_hit    = 1'b1;
          state_nxt = ST_FAIL;
        end
`endif
      end
      ST_RELEASE: begin
        if (db == '0) begin
          if (idx_last) begin
            state_nxt = ST_PASS;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_PASS:  state_nxt = ST_IDLE;
      ST_FAIL:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      idx   <= '0;
      exp_q <= '0;
    end else begin
      if (len_ld) begin
        len_q <= bus.round_len;
      end
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (exp_ld) begin
        exp_q <= bus.rd_data;
      end
    end
  end

`ifdef SEQ_CHECK_TIMEOUT_EN
  // Down-counter armed on entry to PRESS; expiry is the terminal count of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr  <= '0;
      to_q <= 1'b0;
    end else begin
      if (exp_ld) begin
        tmr <= TMR_W'(TIMEOUT_CYC - 1);
      end else if ((state == ST_PRESS) && (tmr != '0)) begin
        tmr <= tmr - 1'b1;
      end
      to_q <= to_hit;
    end
  end

  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.rd_en     = (state == ST_FETCH);
  assign bus.rd_addr   = idx;
  assign bus.busy      = (state == ST_FETCH) || (state == ST_WAIT_RD) ||
                         (state == ST_PRESS) || (state == ST_RELEASE);
  assign bus.pass      = (state == ST_PASS);
  assign bus.fail      = (state == ST_FAIL);
  assign bus.press_idx = idx;
  assign bus.echo_led  = db;

endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker: rounds are modelled from the game rules,
// expectations queued at stimulus time and checked by an independent output monitor.
module tb_sequence_checker;
  localparam int MAX_LEN = 8;
  localparam int CODE_W  = 2;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sequence_checker_if #(.MAX_LEN(MAX_LEN), .CODE_W(CODE_W)) bus();

  sequence_checker #(.MAX_LEN(MAX_LEN), .CODE_W(CODE_W), .DEBOUNCE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int is_pass;
    int to;
    int idx;
  } res_t;

  res_t exp_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mem[8];
  logic [3:0] pmask[8];
  bit   pbounce[8];
  res_t mon_r;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Sequence memory: data valid exactly one cycle after rd_en, garbage otherwise.
  initial begin
    bit rd_v;
    int ra;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      rd_v = bus.rd_en;
      ra   = int'(bus.rd_addr);
      @(posedge clk);
      #1;
      bus.rd_data = rd_v ? CODE_W'(mem[ra]) : CODE_W'($urandom);
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got rd_addr %0d expected no read", bus.rd_addr);
        end else begin
          check("rd_addr", int'(bus.rd_addr), addr_q.pop_front());
        end
      end
      if (bus.pass || bus.fail) begin
        check("pass_fail_excl", int'(bus.pass & bus.fail), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got pass=%0b fail=%0b expected none", bus.pass, bus.fail);
        end else begin
          mon_r = exp_q.pop_front();
          check("result_pass", int'(bus.pass), mon_r.is_pass);
          check("result_fail", int'(bus.fail), 1 - mon_r.is_pass);
          check("result_timeout", int'(bus.timeout), mon_r.to);
          check("result_idx", int'(bus.press_idx), mon_r.idx);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_led(input logic [3:0] tgt, input string name);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.echo_led == tgt) break;
    end
    check(name, int'(bus.echo_led), int'(tgt));
  endtask

  task automatic do_start(input int len);
    bus.round_len = LEN_W'(len);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_to_rd_en", int'(bus.rd_en), int'(len >= 1 && len <= MAX_LEN));
    @(posedge clk);
    #1;
  endtask

  task automatic gen_round(input int err_pct);
    for (int i = 0; i < 8; i++) begin
      mem[i]     = int'($urandom_range(0, 3));
      pbounce[i] = ($urandom_range(0, 3) == 0);
      pmask[i]   = 4'b0001 << mem[i];
      if (int'($urandom_range(0, 99)) < err_pct) begin
        if ($urandom_range(0, 1) == 1)
          pmask[i] = 4'b0001 << ((mem[i] + int'($urandom_range(1, 3))) % 4);
        else
          pmask[i] = pmask[i] | (4'b0001 << ((mem[i] + int'($urandom_range(1, 3))) % 4));
      end
    end
  endtask

  task automatic run_round(input int len, input bit mid_start, input bit held);
    int   np;
    int   fail_at;
    res_t r;
    fail_at = -1;
    // Reference: presses are judged in order; first non-matching press ends the round.
    if (len < 1 || len > MAX_LEN) begin
      np = 0;
      r  = '{0, 0, 0};
    end else begin
      np = len;
      for (int i = 0; i < len; i++) begin
        addr_q.push_back(i);
        if (pmask[i] != (4'b0001 << mem[i])) begin
          fail_at = i;
          np      = i + 1;
          break;
        end
      end
      if (fail_at < 0) r = '{1, 0, len - 1};
      else             r = '{0, 0, fail_at};
    end
    exp_q.push_back(r);

    if (held) begin
      bus.btn = 4'b0001 << mem[0];
      wait_led(4'b0001 << mem[0], "held_level");
      @(posedge clk);
      #1;
    end
    do_start(len);
    if (held) begin
      tick(4);
      bus.btn = '0;
      wait_led(4'b0000, "held_release");
      @(posedge clk);
      #1;
      tick(3);
      check("held_not_press", int'(bus.press_idx), 0);
      check("held_busy", int'(bus.busy), 1);
    end

    for (int i = 0; i < np; i++) begin
      if (mid_start && i == 1) begin
        bus.round_len = LEN_W'($urandom_range(0, 15));
        bus.start     = 1'b1;
        tick(1);
        bus.start = 1'b0;
      end
      if (pbounce[i]) begin
        repeat (2) begin
          bus.btn = pmask[i];
          tick(1);
          bus.btn = '0;
          tick(1);
        end
      end
      bus.btn = pmask[i];
      wait_led(pmask[i], "press_seen");
      if (i == fail_at) begin
        @(negedge clk);
        check("fail_latency", int'(bus.fail), 1);
      end
      @(posedge clk);
      #1;
      tick(int'($urandom_range(0, 6)));
      bus.btn = '0;
      wait_led(4'b0000, "release_seen");
      if (fail_at < 0 && i == np - 1) begin
        @(negedge clk);
        check("pass_latency", int'(bus.pass), 1);
      end
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 50; k++) begin
      if (!bus.busy) break;
      tick(1);
    end
    check("round_done", int'(bus.busy), 0);
    tick(int'($urandom_range(1, 4)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int low_cnt;
    bus.start     = 1'b0;
    bus.round_len = '0;
    bus.btn       = '0;
    tick(3);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pass", int'(bus.pass), 0);
    check("rst_fail", int'(bus.fail), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    check("rst_rd_en", int'(bus.rd_en), 0);
    check("rst_rd_addr", int'(bus.rd_addr), 0);
    check("rst_press_idx", int'(bus.press_idx), 0);
    check("rst_echo_led", int'(bus.echo_led), 0);
    rst_n = 1'b1;
    tick(2);

    // Clean three-press round
    gen_round(0);
    mem[0] = 2; mem[1] = 0; mem[2] = 3;
    for (int i = 0; i < 3; i++) begin pmask[i] = 4'b0001 << mem[i]; pbounce[i] = 1'b0; end
    run_round(3, 1'b0, 1'b0);

    // Wrong second press
    mem[0] = 1; mem[1] = 1;
    pmask[0] = 4'b0010; pmask[1] = 4'b0100;
    pbounce[0] = 1'b0; pbounce[1] = 1'b0;
    run_round(2, 1'b0, 1'b0);

    // Bouncy first press must count once
    mem[0] = 0; mem[1] = 1;
    pmask[0] = 4'b0001; pmask[1] = 4'b0010;
    pbounce[0] = 1'b1; pbounce[1] = 1'b0;
    run_round(2, 1'b0, 1'b0);

    // Two buttons at once, then illegal lengths
    mem[0] = 1; pmask[0] = 4'b1010; pbounce[0] = 1'b0;
    run_round(1, 1'b0, 1'b0);
    run_round(0, 1'b0, 1'b0);
    run_round(9, 1'b0, 1'b0);

    // Button already held at start
    gen_round(0);
    mem[0] = 3; mem[1] = 2;
    pmask[0] = 4'b1000; pmask[1] = 4'b0100;
    run_round(2, 1'b0, 1'b1);

    // Randomized rounds
    for (int n = 0; n < 30; n++) begin
      gen_round(10);
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(9, 15));
      else len = int'($urandom_range(1, MAX_LEN));
      run_round(len, ($urandom_range(0, 3) == 0), 1'b0);
    end

    // No press at all
    mem[0] = 2;
    addr_q.push_back(0);
`ifdef SEQ_CHECK_TIMEOUT_EN
    exp_q.push_back('{0, 1, 0});
    do_start(1);
    low_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      tick(1);
      low_cnt++;
      if (!bus.busy) break;
    end
    check("timeout_window", int'(low_cnt >= 198 && low_cnt <= 206), 1);
`else
    do_start(1);
    low_cnt = 0;
    repeat (1000) begin
      tick(1);
      if (!bus.busy) low_cnt++;
    end
    check("busy_held_1000", low_cnt, 0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    addr_q.delete();
    tick(2);
    rst_n = 1'b1;
`endif
    tick(3);

    // Reset in the middle of a round at press index 1
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    for (int i = 0; i < 3; i++) begin pmask[i] = 4'b0001 << mem[i]; pbounce[i] = 1'b0; end
    addr_q.push_back(0);
    addr_q.push_back(1);
    do_start(3);
    bus.btn = pmask[0];
    wait_led(pmask[0], "rst_round_press");
    @(posedge clk);
    #1;
    bus.btn = '0;
    wait_led(4'b0000, "rst_round_release");
    @(posedge clk);
    #1;
    tick(3);
    check("idx_before_rst", int'(bus.press_idx), 1);
    check("busy_before_rst", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_pass", int'(bus.pass), 0);
    check("rst_mid_fail", int'(bus.fail), 0);
    check("rst_mid_idx", int'(bus.press_idx), 0);
    exp_q.delete();
    addr_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_round(3, 1'b0, 1'b0);

    tick(5);
    check("results_drained", exp_q.size(), 0);
    check("reads_drained", addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
